// File: rtl/reg_bank_sb.sv
// reg_bank_sb: register bank for the decode stage with a pending-write scoreboard.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   w_en, w_reg, w_data    writeback port (array update on the edge, bypassed to reads)
//   r_reg1/2, read_data1/2 two combinational read ports
//   iss_en, iss_reg        issue of an instruction that will write iss_reg
//   busy1/2, stall         source registers with an outstanding write
//   pend_cnt               number of scoreboard bits set (registered)
//   waw_err                sticky write-after-write violation flag
//
// Register 0 and addresses >= DEPTH are not real registers. Writes and issues
// to them are dropped, and reads of them return zero.
module reg_bank_sb #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADD_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w_en,
  input  logic [ADD_WIDTH-1:0] w_reg,
  input  logic [WIDTH-1:0]     w_data,
  input  logic [ADD_WIDTH-1:0] r_reg1,
  input  logic [ADD_WIDTH-1:0] r_reg2,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2,
  input  logic                 iss_en,
  input  logic [ADD_WIDTH-1:0] iss_reg,
  output logic                 busy1,
  output logic                 busy2,
  output logic                 stall,
  output logic [ADD_WIDTH:0]   pend_cnt,
  output logic                 waw_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADD_WIDTH:0] DEPTH_W = (ADD_WIDTH+1)'(DEPTH);

  function automatic logic addr_ok(input logic [ADD_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_W);
  endfunction

  logic [WIDTH-1:0]   regs_q [DEPTH];
  logic [DEPTH-1:0]   sb_q, sb_d;
  logic [ADD_WIDTH:0] pend_q, pend_d;
  logic               waw_q, waw_d;

  logic             w_ok, iss_ok, r1_ok, r2_ok;
  logic [IDX_W-1:0] w_idx, iss_idx, r1_idx, r2_idx;
  logic             inc, dec;

  assign w_ok    = w_en && addr_ok(w_reg);
  assign iss_ok  = iss_en && addr_ok(iss_reg);
  assign r1_ok   = addr_ok(r_reg1);
  assign r2_ok   = addr_ok(r_reg2);
  // Only used once the full address has been range checked.
  assign w_idx   = w_reg[IDX_W-1:0];
  assign iss_idx = iss_reg[IDX_W-1:0];
  assign r1_idx  = r_reg1[IDX_W-1:0];
  assign r2_idx  = r_reg2[IDX_W-1:0];

  // Register array: entry 0 is a constant zero, the others load on writeback.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      always_ff @(posedge clk) regs_q[gi] <= '0;
    end else begin : g_data
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_q[gi] <= '0;
        end else if (w_ok && (w_idx == IDX_W'(gi))) begin
          regs_q[gi] <= w_data;
        end
      end
    end
  end

  // Scoreboard next state. The set is applied after the clear so that a new
  // producer issuing while the old one retires leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (w_ok)   sb_d[w_idx]   = 1'b0;
    if (iss_ok) sb_d[iss_idx] = 1'b1;
    sb_d[0] = 1'b0;

    inc = iss_ok && !sb_q[iss_idx];
    dec = w_ok && sb_q[w_idx] && !(iss_ok && (iss_idx == w_idx));
    pend_d = pend_q + {{ADD_WIDTH{1'b0}}, inc} - {{ADD_WIDTH{1'b0}}, dec};

    // Issuing onto a register that still has a producer in flight, unless
    // that producer retires on this very edge.
    waw_d = waw_q | (iss_ok && sb_q[iss_idx] && !(w_ok && (w_idx == iss_idx)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      pend_q <= '0;
      waw_q  <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
      waw_q  <= waw_d;
    end
  end

  // Read ports. A valid writeback implies a valid address, so the bypass
  // match needs no separate range check on the read side.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    busy1      = 1'b0;
    busy2      = 1'b0;
    if (!rst) begin
      if (w_ok && (w_reg == r_reg1)) read_data1 = w_data;
      else if (r1_ok)                read_data1 = regs_q[r1_idx];
      if (w_ok && (w_reg == r_reg2)) read_data2 = w_data;
      else if (r2_ok)                read_data2 = regs_q[r2_idx];
      busy1 = r1_ok && sb_q[r1_idx] && !(w_en && (w_reg == r_reg1));
      busy2 = r2_ok && sb_q[r2_idx] && !(w_en && (w_reg == r_reg2));
    end
  end

  assign stall    = busy1 | busy2;
  assign pend_cnt = pend_q;
  assign waw_err  = waw_q;

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank with a per-register pending-write scoreboard, for the pipelined CPU's decode stage. It provides two asynchronous read ports and one synchronous write port, with write-to-read bypass, and a synchronous clear of every register. The scoreboard is set when an instruction that writes a register issues and cleared when that result is written back. It drives the stall signal to decode and a sticky flag for write-after-write (WAW) violations.

## Interface
- WIDTH, 8, data width of each register.
- DEPTH, 16, number of registers; register 0 always reads as zero.
- ADD_WIDTH, 5, address width; addresses ≥ DEPTH are out of range.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  writeback strobe.
- w_reg  in  ADD_WIDTH  writeback destination.
- w_data  in  WIDTH  writeback data.
- r_reg1, r_reg2  in  ADD_WIDTH  read source addresses.
- read_data1, read_data2  out  WIDTH  read data.
- iss_en  in  1  an instruction with a destination issues this cycle.
- iss_reg  in  ADD_WIDTH  destination of the issuing instruction.
- busy1, busy2  out  1  the corresponding source has an outstanding write.
- stall  out  1  busy1 | busy2.
- pend_cnt  out  ADD_WIDTH+1  number of scoreboard bits currently set.
- waw_err  out  1  sticky WAW violation flag.

## Operation
- Valid address: nonzero and < DEPTH. Writes and issues to invalid addresses are ignored, with no state change and no waw_err.
- Write: on the edge with w_en=1 and w_reg valid, registers[w_reg] <= w_data.
- Read (combinational):
  - Bypass: if w_en=1, w_reg valid and w_reg == r_regN, then read_dataN = w_data.
  - Otherwise, if r_regN is valid, read_dataN = registers[r_regN].
  - Otherwise read_dataN = 0.
- Scoreboard sb[DEPTH-1:1], one bit per register.
  - Clear: on the edge with w_en=1 and w_reg valid, sb[w_reg] <= 0.
  - Set: on the edge with iss_en=1 and iss_reg valid, sb[iss_reg] <= 1.
  - Same register set and cleared in one cycle: set wins, so the bit ends at 1. This is a new producer issuing while the old one retires.
- busyN = r_regN valid && sb[r_regN] && !(w_en && w_reg == r_regN). The bypass covers a register being written back in the same cycle.
- waw_err: set on the edge when iss_en=1, iss_reg is valid, sb[iss_reg]=1 and the same cycle does not clear that bit. Once set, it stays set until rst.
- pend_cnt: registered. Each cycle it equals the previous value, plus 1 if a 0→1 transition occurs, minus 1 if a 1→0 transition occurs (net 0 if both). It always equals popcount(sb) and never wraps; the maximum is DEPTH-1.
- Writeback to a register whose sb bit is 0 is legal: data is written and the scoreboard is unchanged.

## Timing
- Reset, on the edge with rst=1:
  - All registers, sb, pend_cnt and waw_err become 0.
  - Writes and issues in that cycle are discarded; rst has priority.
- While rst=1: read_data1/2 = 0, busy1/2 = 0, stall = 0.
- Reset asserted mid-operation discards all pending bits. No write that is still in flight is preserved.
- Write latency: 0 cycles to the read ports via bypass; the array holds the value from the next cycle.
- Issue latency: busy is visible starting the cycle after iss_en. An instruction issuing in cycle N and reading the same register in cycle N is not self-stalled.
- pend_cnt and waw_err update one cycle after the causing event.
- Reads of both ports to the same address return identical data and identical busy values.

## Test plan
- Reset, then write 0xA5 to r3 and read r3 on both ports:
  - read_data1/2 = 0xA5 in the same cycle via bypass, and on subsequent cycles from the array.
  - Then read r0: 0x00.
- Write 0xFF to r0 and to r20 (DEPTH=16), then read them back:
  - Both read 0x00.
  - busy stays 0, pend_cnt stays 0 and waw_err stays 0.
- Issue r5, then read r5:
  - busy1=1 and stall=1 from the next cycle; pend_cnt=1.
  - Writeback 0x3C to r5 with r_reg1=5: busy1=0, read_data1=0x3C in that cycle, and pend_cnt=0 on the next cycle.
- In one cycle, issue r7 while writing back r7 (sb[7]=1):
  - sb[7] stays 1, pend_cnt is unchanged and waw_err=0.
  - Next, issue r7 again with no writeback: waw_err=1, and it remains 1.
- Issue r1..r15 on consecutive cycles:
  - pend_cnt reaches 15.
  - Assert rst mid-sequence: the next cycle has pend_cnt=0, all reads = 0 and waw_err=0.
